// File: rtl/spi_ram_responder.sv
// SPI mode-0 target emulating a small byte-addressed serial SRAM (READ 0x03 / WRITE 0x02).
// Optional fast read (0x0B with one dummy byte) is enabled by defining SPI_RAM_RESP_FAST_READ_EN.
module spi_ram_responder #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          CLK,
    input  logic          CS_N,
    input  logic          MOSI,
    output logic          MISO,
    output logic          busy,
    output logic          wr_pulse,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [2:0]    dbg_state
);

    // Handshake: none; the SPI initiator owns all timing, this block only follows pin edges.
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WRITE,
        S_READ,
`ifdef SPI_RAM_RESP_FAST_READ_EN
        S_DUMMY,
`endif
        S_IGNORE
    } state_t;

    state_t state, state_next;

    logic [7:0]    mem [DEPTH];
    logic [2:0]    sck_sync;
    logic [2:0]    cs_sync;
    logic [1:0]    mosi_sync;
    logic [4:0]    bit_cnt;
    logic [7:0]    cmd_sr;
    logic [AW-1:0] addr_sr;
    logic [7:0]    data_sr;
    logic [7:0]    tx_sr;
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_inc;
    logic [AW-1:0] addr_full;
    logic [7:0]    cmd_byte;
    logic [7:0]    wr_byte;
    logic          is_read;
    logic          is_fast;
    logic          mosi_bit;
    logic          sck_rise, sck_fall, cs_rise, cs_fall;
    logic          byte_done, addr_done, wr_en;

    // Synchronizers carry no reset so a reset mid-frame cannot fabricate a CS_N edge.
    always_ff @(posedge clk) begin
        sck_sync  <= {sck_sync[1:0], CLK};
        cs_sync   <= {cs_sync[1:0], CS_N};
        mosi_sync <= {mosi_sync[0], MOSI};
    end

    assign sck_rise  = sck_sync[1] & ~sck_sync[2];
    assign sck_fall  = ~sck_sync[1] & sck_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign mosi_bit  = mosi_sync[1];

    assign byte_done = sck_rise && (bit_cnt[2:0] == 3'd7);
    assign addr_done = sck_rise && (bit_cnt == 5'd23);
    assign cmd_byte  = {cmd_sr[6:0], mosi_bit};
    assign wr_byte   = {data_sr[6:0], mosi_bit};
    assign addr_full = {addr_sr[AW-2:0], mosi_bit};
    assign ptr_inc   = ptr + AW'(1);
    assign wr_en     = !reset && !cs_rise && (state == S_WRITE) && byte_done;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cs_rise) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (cs_fall) state_next = S_CMD;
                S_CMD: if (byte_done) begin
                    case (cmd_byte)
                        8'h02, 8'h03: state_next = S_ADDR;
`ifdef SPI_RAM_RESP_FAST_READ_EN
                        8'h0B:        state_next = S_ADDR;
`endif
                        default:      state_next = S_IGNORE;
                    endcase
                end
                S_ADDR: if (addr_done) begin
                    if (!is_read)     state_next = S_WRITE;
`ifdef SPI_RAM_RESP_FAST_READ_EN
                    else if (is_fast) state_next = S_DUMMY;
`endif
                    else              state_next = S_READ;
                end
`ifdef SPI_RAM_RESP_FAST_READ_EN
                S_DUMMY: if (byte_done) state_next = S_READ;
`endif
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr] <= wr_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt  <= '0;
            cmd_sr   <= '0;
            addr_sr  <= '0;
            data_sr  <= '0;
            tx_sr    <= '0;
            ptr      <= '0;
            is_read  <= 1'b0;
            is_fast  <= 1'b0;
            MISO     <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_pulse <= 1'b0;
            if (cs_fall)      busy <= 1'b1;
            else if (cs_rise) busy <= 1'b0;

            if (state_next != state) bit_cnt <= '0;
            else if (sck_rise)       bit_cnt <= bit_cnt + 5'd1;

            if (sck_rise) begin
                cmd_sr  <= cmd_byte;
                addr_sr <= addr_full;
                data_sr <= wr_byte;
            end

            // MISO only carries data inside READ; every other path forces it low.
            if (cs_rise || state != S_READ) begin
                MISO <= 1'b0;
            end else if (sck_fall) begin
                MISO  <= tx_sr[7];
                tx_sr <= {tx_sr[6:0], 1'b0};
            end

            if (!cs_rise) begin
                case (state)
                    S_CMD: if (byte_done) begin
                        is_read <= (cmd_byte != 8'h02);
                        is_fast <= (cmd_byte == 8'h0B);
                    end
                    S_ADDR: if (addr_done) begin
                        ptr   <= addr_full;
                        tx_sr <= mem[addr_full];
                    end
`ifdef SPI_RAM_RESP_FAST_READ_EN
                    S_DUMMY: if (byte_done) tx_sr <= mem[ptr];
`endif
                    S_WRITE: if (byte_done) begin
                        wr_pulse <= 1'b1;
                        wr_addr  <= ptr;
                        wr_data  <= wr_byte;
                        ptr      <= ptr_inc;
                    end
                    S_READ: if (byte_done) begin
                        ptr   <= ptr_inc;
                        tx_sr <= mem[ptr_inc];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: SPI frames driven bit by bit, commits and read bytes
// checked against queues filled from a local memory model.
module tb_spi_ram_responder;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       CLK = 1'b0;
    logic       CS_N = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic       busy;
    logic       wr_pulse;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] dbg_state;

    logic [13:0] exp_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  tb_mem [64];
    logic [5:0]  wptr;
    logic [7:0]  rx;
    int tests = 0;
    int fails = 0;

    spi_ram_responder #(.DEPTH(64), .AW(6)) dut (
        .clk(clk), .reset(reset), .CLK(CLK), .CS_N(CS_N), .MOSI(MOSI),
        .MISO(MISO), .busy(busy), .wr_pulse(wr_pulse), .wr_addr(wr_addr),
        .wr_data(wr_data), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard for committed bytes
    always @(negedge clk) begin
        if (!reset && wr_pulse === 1'b1) begin
            logic [13:0] e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL wr_unexpected: observed addr %h data %h, required no commit", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                assert ({wr_addr, wr_data} === e) else begin
                    fails++;
                    $error("FAIL wr_commit: observed %h/%h required %h/%h", wr_addr, wr_data, e[13:8], e[7:0]);
                end
            end
        end
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            MOSI = tx[7-i];
            repeat (HALF) @(negedge clk);
            r = {r[6:0], MISO};
            CLK = 1'b1;
            repeat (HALF) @(negedge clk);
            CLK = 1'b0;
        end
    endtask

    task automatic cs_select();
        CS_N = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_deselect();
        repeat (HALF) @(negedge clk);
        CS_N = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        logic [7:0] d;
        spi_bits(cmd, 8, d);
        spi_bits(addr[23:16], 8, d);
        spi_bits(addr[15:8], 8, d);
        spi_bits(addr[7:0], 8, d);
    endtask

    task automatic write_byte(input logic [7:0] d);
        logic [7:0] r;
        exp_q.push_back({wptr, d});
        tb_mem[wptr] = d;
        wptr = wptr + 6'd1;
        spi_bits(d, 8, r);
    endtask

    task automatic read_byte(input string tag);
        logic [7:0] r;
        logic [7:0] e;
        spi_bits(8'h00, 8, r);
        e = rd_q.pop_front();
        check8(tag, r, e);
    endtask

    initial begin
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check8("rst_miso", {7'd0, MISO}, 8'h00);
        check8("rst_busy", {7'd0, busy}, 8'h00);
        check8("rst_wr_pulse", {7'd0, wr_pulse}, 8'h00);
        check8("rst_wr_addr", {2'd0, wr_addr}, 8'h00);
        check8("rst_wr_data", wr_data, 8'h00);

        // write DE AD BE EF at 0x10
        cs_select();
        check8("busy_sel", {7'd0, busy}, 8'h01);
        send_hdr(8'h02, 24'h000010);
        wptr = 6'h10;
        write_byte(8'hDE); write_byte(8'hAD); write_byte(8'hBE); write_byte(8'hEF);
        cs_deselect();
        check8("busy_desel", {7'd0, busy}, 8'h00);

        // read it back
        cs_select();
        send_hdr(8'h03, 24'h000010);
        for (int i = 0; i < 4; i++) rd_q.push_back(tb_mem[6'h10 + i[5:0]]);
        read_byte("rd_10"); read_byte("rd_11"); read_byte("rd_12"); read_byte("rd_13");
        cs_deselect();

        // write across the top of memory, read back via an aliased address
        cs_select();
        send_hdr(8'h02, 24'h00003F);
        wptr = 6'h3F;
        write_byte(8'h11); write_byte(8'h22);
        cs_deselect();
        cs_select();
        send_hdr(8'h03, 24'hFFFF3F);
        rd_q.push_back(8'h11); rd_q.push_back(8'h22);
        read_byte("rd_wrap_3f"); read_byte("rd_wrap_00");
        cs_deselect();

        // unknown command: MISO stays low, nothing commits
        cs_select();
        for (int i = 0; i < 6; i++) begin
            spi_bits((i == 0) ? 8'h9F : 8'hFF, 8, rx);
            check8("ign_miso", rx, 8'h00);
        end
        cs_deselect();
        cs_select();
        send_hdr(8'h03, 24'h000000);
        rd_q.push_back(tb_mem[0]);
        read_byte("ign_mem0");
        cs_deselect();

        // partial second byte is dropped
        cs_select();
        send_hdr(8'h02, 24'h000006);
        wptr = 6'h06;
        write_byte(8'h77);
        cs_deselect();
        cs_select();
        send_hdr(8'h02, 24'h000005);
        wptr = 6'h05;
        write_byte(8'hA5);
        spi_bits(8'h3C, 5, rx);
        cs_deselect();
        cs_select();
        send_hdr(8'h03, 24'h000005);
        rd_q.push_back(8'hA5); rd_q.push_back(8'h77);
        read_byte("part_05"); read_byte("part_06");
        cs_deselect();

        // fast read command
        cs_select();
        send_hdr(8'h0B, 24'h000010);
        spi_bits(8'h00, 8, rx);
        check8("fast_dummy", rx, 8'h00);
`ifdef SPI_RAM_RESP_FAST_READ_EN
        rd_q.push_back(8'hDE); rd_q.push_back(8'hAD);
`else
        rd_q.push_back(8'h00); rd_q.push_back(8'h00);
`endif
        read_byte("fast_b0"); read_byte("fast_b1");
        cs_deselect();

        // reset in the middle of a read
        cs_select();
        send_hdr(8'h03, 24'h000010);
        rd_q.push_back(8'hDE);
        read_byte("rst_rd_b0");
        spi_bits(8'h00, 3, rx);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check8("midrst_miso", {7'd0, MISO}, 8'h00);
        check8("midrst_busy", {7'd0, busy}, 8'h00);
        spi_bits(8'hFF, 5, rx);
        check8("midrst_tail", rx, 8'h00);
        spi_bits(8'hFF, 8, rx);
        check8("midrst_next", rx, 8'h00);
        check8("midrst_busy2", {7'd0, busy}, 8'h00);
        cs_deselect();
        cs_select();
        send_hdr(8'h03, 24'h000010);
        rd_q.push_back(8'hDE); rd_q.push_back(8'hAD);
        read_byte("post_rst_b0"); read_byte("post_rst_b1");
        cs_deselect();

        repeat (10) @(negedge clk);
        check8("commits_left", 8'(exp_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_ram_responder.md
# spi_ram_responder

SPI mode-0 target that emulates a byte-addressed serial SRAM (23LC1024-style command set) backed by an internal register array. It is the far end of the SPI RAM link driven by the memory-mapped SPI RAM initiator. It serves as a bench/FPGA stand-in for the external RAM chip and as an on-die scratch target. SPI pins are oversampled on the system clock; no second clock domain exists.

## Interface
Parameters:
- `DEPTH`, 64 — bytes of storage; power of two, 16..256.
- `AW`, 6 — log2(DEPTH); address bits used, upper address bits ignored.

Ports:
- `clk` in 1 — system clock; the only clock.
- `reset` in 1 — synchronous, active-high.
- `CLK` in 1 — SPI SCK from initiator, asynchronous.
- `CS_N` in 1 — SPI chip select, active-low, asynchronous.
- `MOSI` in 1 — SPI data in, asynchronous.
- `MISO` out 1 — SPI data out; driven 0 whenever deselected (no tristate).
- `busy` out 1 — 1 while synchronized CS_N is low.
- `wr_pulse` out 1 — one-cycle pulse when a data byte is committed.
- `wr_addr` out AW — address of committed byte, valid with `wr_pulse`.
- `wr_data` out 8 — committed byte, valid with `wr_pulse`.

## Operation
- CLK, CS_N, MOSI each pass a 2-flop synchronizer; a third flop on CLK gives rise/fall strobes. CS_N falling or rising is detected the same way.
- SPI mode 0, MSB first: MOSI sampled on SCK rise; MISO updated on SCK fall.
- Frame: 8-bit command, 24-bit address (MSB first), then data bytes until CS_N rises.
- States: IDLE, CMD, ADDR, WRITE, READ, IGNORE (plus DUMMY under macro).
- IDLE -> CMD on CS_N fall; bit counter cleared.
- CMD, after 8 rises: 0x02 -> ADDR(write), 0x03 -> ADDR(read), other -> IGNORE.
- ADDR, after 24 rises: pointer = addr[AW-1:0]. Write -> WRITE. Read -> load shift register with mem[pointer], -> READ.
- WRITE: on every 8th rise, mem[pointer] <= byte, `wr_pulse` asserted, pointer increments.
- READ: MISO = shift[7] updated on each SCK fall; after 8th rise of a byte, pointer increments and next byte is loaded so its bit 7 appears on the following fall.
- Pointer wraps DEPTH-1 -> 0 in both directions of use (sequential mode only).
- IGNORE: MISO held 0, no writes, until CS_N rises.
- CS_N rise in any state -> IDLE next cycle; a partial (<8 bit) write byte is discarded; MISO -> 0.
- Memory is not reset; contents survive `reset`. Power-up contents undefined.

## Timing
- Reset values: state IDLE, MISO 0, busy 0, wr_pulse 0, wr_addr 0, wr_data 0, counters 0.
- Pin-to-strobe latency: 3 `clk` cycles from SCK/CS_N edge to internal strobe.
- Requirement on initiator: SCK high and low phases each ≥ 4 `clk`; CS_N low to first SCK rise ≥ 4 `clk`; last SCK fall to CS_N rise ≥ 4 `clk`.
- MISO changes within 4 `clk` of SCK fall pin edge; stable for initiator's following rise.
- `wr_pulse` occurs 1 cycle after the strobe of the byte's 8th rise; memory write happens the same cycle.
- `busy` follows CS_N with 3-cycle latency.
- `reset` mid-transaction: state IDLE next cycle; remaining frame is treated as IGNORE-equivalent until CS_N rises and falls again (a new frame requires a fresh CS_N fall).
- Simultaneous CS_N rise and SCK rise strobes: CS_N wins; bit discarded.

## Configuration
- `SPI_RAM_RESP_FAST_READ_EN` defined: command 0x0B accepted; after address, DUMMY state consumes 8 SCK rises (MISO 0), then READ identical to 0x03.
- Not defined: 0x0B decodes as unknown -> IGNORE; DUMMY state absent.

## Test plan
- Write frame 0x02, addr 0x000010, data 0xDE 0xAD 0xBE 0xEF -> four `wr_pulse` with wr_addr 0x10..0x13; read frame 0x03, 0x000010, 32 clocks -> MISO returns 0xDEADBEEF.
- Write 0x11,0x22 at addr DEPTH-1 (0x00003F) -> wr_addr 0x3F then 0x00; read from 0x3F -> 0x11, 0x22; addr 0xFFFF3F aliases to 0x3F.
- Command 0x9F, 6 bytes of 0xFF -> MISO 0 throughout, no `wr_pulse`, memory at 0x00 unchanged.
- Write frame at 0x05, 0xA5 then CS_N rises after 5 bits of second byte -> one `wr_pulse` (0x05/0xA5), 0x06 unchanged.
- With macro: 0x0B, 0x000010, dummy 0x00, 16 clocks -> 0xDEAD; without macro same frame -> MISO 0, no change.
- Assert `reset` during READ data phase -> MISO 0 and busy 0 next cycles; new frame after CS_N toggle reads previously written data intact.
